// File: rtl/coef_mac_sequencer.sv
// coef_mac_sequencer: applies one coefficient-table row to A/B through a shared multiplier, one column per cycle
module coef_mac_sequencer #(
   parameter int W    = 8,
   parameter int N    = 4,
   parameter int TEMP = 21,
   parameter int BMUL = 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [W-1:0]         A,
   input  logic [W-1:0]         B,
   input  logic [$clog2(N)-1:0] ROW,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [W-1:0]         XOUT,
   input  logic                 CFG_WE,
   input  logic [$clog2(N)-1:0] CFG_ROW,
   input  logic [$clog2(N)-1:0] CFG_COL,
   input  logic [W-1:0]         CFG_DATA,
   output logic                 BUSY
);
   localparam int LN = $clog2(N);
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state, state_nx;
   logic [W-1:0] coef [N*N];
   logic [W-1:0] acc, xout_q, term, acc_nx;
   logic [LN-1:0] row_q, col_q;
   logic last;
   assign term   = W'(TEMP) * coef[{row_q, col_q}];
   assign acc_nx = acc - term;
   assign last   = col_q == LN'(N - 1);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = IN_VALID ? MAC : IDLE;
         MAC:     state_nx = last ? OUT : MAC;
         OUT:     state_nx = OUT_READY ? IDLE : OUT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         acc    <= '0;
         row_q  <= '0;
         col_q  <= '0;
         xout_q <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && IN_VALID) begin
            acc   <= A - W'(BMUL) * B;
            row_q <= ROW;
            col_q <= '0;
         end else if (state == MAC) begin
            acc   <= acc_nx;
            col_q <= last ? col_q : col_q + 1'b1;
            if (last) xout_q <= acc_nx;
         end
      end
   end
   // reads above see the pre-write entry because both update on the same edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < N * N; i++) coef[i] <= W'(i);
      end else if (CFG_WE) begin
         coef[{CFG_ROW, CFG_COL}] <= CFG_DATA;
      end
   end
   assign IN_READY  = state == IDLE && !RST;
   assign OUT_VALID = state == OUT;
   assign BUSY      = state != IDLE;
   assign XOUT      = xout_q;
endmodule

// File: tb/tb_coef_mac_sequencer.sv
// tb_coef_mac_sequencer: randomized check of coef_mac_sequencer against a transaction-level model
module tb_coef_mac_sequencer;
   localparam int N = 4;
   logic CLK = 0, RST = 1;
   logic IN_VALID = 0, IN_READY, OUT_VALID, OUT_READY = 0, BUSY, CFG_WE = 0;
   logic [7:0] A = 0, B = 0, XOUT, CFG_DATA = 0;
   logic [1:0] ROW = 0, CFG_ROW = 0, CFG_COL = 0;
   int vectors = 0, errors = 0;
   int phase, k, mrow, macc;
   logic [7:0] mxout;
   logic [7:0] mtbl [N][N];
   bit rnd_cfg = 0;

   coef_mac_sequencer dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A(A), .B(B), .ROW(ROW),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .XOUT(XOUT), .CFG_WE(CFG_WE),
      .CFG_ROW(CFG_ROW), .CFG_COL(CFG_COL), .CFG_DATA(CFG_DATA), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      phase = 0; k = 0; mrow = 0; macc = 0; mxout = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) mtbl[r][c] = 8'(r * N + c);
   endtask

   // one transaction at a time: idle -> N MAC edges -> held result
   task automatic advance();
      if (phase == 0 && IN_VALID) begin
         macc = int'(A) - 3 * int'(B); mrow = ROW; k = 0; phase = 1;
      end else if (phase == 1) begin
         macc = macc - 21 * int'(mtbl[mrow][k]);
         k++;
         if (k == N) begin phase = 2; mxout = 8'(macc); end
      end else if (phase == 2 && OUT_READY) phase = 0;
      if (CFG_WE) mtbl[CFG_ROW][CFG_COL] = CFG_DATA;
   endtask

   task automatic tick();
      if (rnd_cfg) begin
         CFG_WE = ($urandom % 3) == 0;
         CFG_ROW = 2'($urandom); CFG_COL = 2'($urandom); CFG_DATA = 8'($urandom);
      end
      @(posedge CLK);
      #1;
      advance();
      chk("in_ready", {31'd0, IN_READY}, {31'd0, phase == 0});
      chk("out_valid", {31'd0, OUT_VALID}, {31'd0, phase == 2});
      chk("busy", {31'd0, BUSY}, {31'd0, phase != 0});
      chk("xout", {24'd0, XOUT}, {24'd0, mxout});
   endtask

   task automatic request(input logic [7:0] a, input logic [7:0] b, input logic [1:0] r,
                          input int hold, input bit pulse, input bit cfg_first, input int exp);
      int n = 0;
      A = a; B = b; ROW = r; IN_VALID = 1;
      while (phase == 0 && n < 20) begin tick(); n++; end
      if (n >= 20) chk("accept_timeout", 0, 1);
      IN_VALID = 0; A = 8'($urandom); B = 8'($urandom);
      if (cfg_first) begin CFG_WE = 1; CFG_ROW = 1; CFG_COL = 0; CFG_DATA = 0; end
      while (phase == 1) begin
         tick();
         if (cfg_first) CFG_WE = 0;
      end
      if (exp >= 0) chk("xout_lit", {24'd0, XOUT}, exp);
      for (int i = 0; i < hold; i++) begin
         IN_VALID = pulse && i == 1;
         tick();
         if (exp >= 0) chk("xout_hold", {24'd0, XOUT}, exp);
      end
      IN_VALID = 0; OUT_READY = 1;
      tick();
      OUT_READY = 0;
   endtask

   initial begin
      reset_model();
      #2;
      chk("rst_in_ready", {31'd0, IN_READY}, 0);
      chk("rst_out_valid", {31'd0, OUT_VALID}, 0);
      chk("rst_xout", {24'd0, XOUT}, 0);
      chk("rst_busy", {31'd0, BUSY}, 0);
      #10 RST = 0;
      tick();
      request(8'd100, 8'd10, 2'd1, 0, 0, 0, 120);
      request(8'd200, 8'd0, 2'd0, 5, 1, 0, 74);
      request(8'd0, 8'd255, 2'd3, 1, 0, 0, 149);
      CFG_WE = 1; CFG_ROW = 2; CFG_COL = 3; CFG_DATA = 8'd255;
      tick();
      CFG_WE = 0;
      request(8'd0, 8'd0, 2'd2, 0, 0, 0, 222);
      request(8'd100, 8'd10, 2'd1, 0, 0, 1, 120);
      request(8'd100, 8'd10, 2'd1, 0, 0, 0, 204);
      A = 8'd100; B = 8'd10; ROW = 1; IN_VALID = 1;
      tick();
      IN_VALID = 0;
      tick();
      #2 RST = 1;
      #1;
      chk("mid_rst_out_valid", {31'd0, OUT_VALID}, 0);
      chk("mid_rst_xout", {24'd0, XOUT}, 0);
      chk("mid_rst_busy", {31'd0, BUSY}, 0);
      chk("mid_rst_in_ready", {31'd0, IN_READY}, 0);
      reset_model();
      #2 RST = 0;
      request(8'd100, 8'd10, 2'd1, 0, 0, 0, 120);
      rnd_cfg = 1;
      for (int t = 0; t < 40; t++)
         request(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom), 0, -1);
      rnd_cfg = 0; CFG_WE = 0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/coef_mac_sequencer.md
Name: coef_mac_sequencer

Overview:
- Multi-cycle controller that sequences a single shared W-bit multiplier over one row of an N×N unsigned coefficient table.
- Computes XOUT = A − BMUL·B − TEMP·Σ_c coef[ROW][c], all modulo 2^W.
- The table is reset-initialised to coef[r][c] = r·N + c and can be rewritten through a config port.
- Sits between an upstream operand producer and a downstream result consumer, each with a valid/ready handshake.

Parameters:
- W, 8, data width of operands, coefficients, accumulator and result.
- N, 4, table dimension (rows and columns); must be a power of 2, ≥2.
- TEMP, 21, constant coefficient multiplier.
- BMUL, 3, constant multiplier applied to B.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- IN_VALID  in  1  operand request valid.
- IN_READY  out  1  block can accept a request.
- A  in  W  operand A.
- B  in  W  operand B.
- ROW  in  log2(N)  table row to apply.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- XOUT  out  W  result.
- CFG_WE  in  1  coefficient write enable.
- CFG_ROW  in  log2(N)  write row.
- CFG_COL  in  log2(N)  write column.
- CFG_DATA  in  W  write data.
- BUSY  out  1  high in MAC or OUT state.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE, acc=0, row/col registers=0.
  - XOUT=0, OUT_VALID=0, BUSY=0.
  - Table restored to coef[r][c] = (r·N+c) mod 2^W.
  - IN_READY=0 while RST is high.
- States: IDLE, MAC, OUT.
- IDLE:
  - IN_READY=1.
  - On IN_VALID at an edge: acc ← A − (BMUL·B truncated to W), row ← ROW, col ← 0, go to MAC.
- MAC:
  - IN_READY=0.
  - Each edge: acc ← acc − (TEMP·coef[row][col] truncated to W), col ← col+1.
  - When col==N−1, go to OUT instead of incrementing.
  - Exactly N MAC edges.
- OUT:
  - OUT_VALID=1, XOUT=acc.
  - XOUT and OUT_VALID stay stable until OUT_READY is high at an edge, then go to IDLE.
  - OUT_VALID falls after that edge.
- Latency: OUT_VALID rises N edges after the accepting edge.
  - IN_READY returns one edge after the output handshake.
  - Minimum request spacing is N+2 cycles; no overlap.
- XOUT holds its last value in IDLE and MAC; only OUT_VALID qualifies it.
- Arithmetic:
  - Every product and difference is truncated to W bits (modular).
  - No saturation, no overflow flag.
- Config writes:
  - Accepted in any state; coef[CFG_ROW][CFG_COL] ← CFG_DATA at the edge.
  - A MAC read at the same edge as a write to that entry uses the pre-write value.
  - Columns read at later edges see the new value.
- IN_VALID while not IDLE is ignored; the producer must hold it until IN_READY.
- IN_VALID with RST high: not accepted.

Test Plan:
- Defaults, A=100, B=10, ROW=1 (row = 4,5,6,7, Σ=22) → after 4 MAC edges OUT_VALID=1, XOUT=120 (70 − 462 mod 256).
- A=200, B=0, ROW=0 (Σ=6) → XOUT=74. Hold OUT_READY=0 for 5 cycles → XOUT=74 and OUT_VALID=1 stable, IN_READY=0, a pulsed IN_VALID is ignored.
- Wrap: A=0, B=255, ROW=3 (Σ=54) → 3·255 mod 256 = 253, acc=3; 21·54 mod 256 = 110 → XOUT=149.
- In IDLE, write CFG coef[2][3]=255, then A=0, B=0, ROW=2 (Σ=282) → XOUT=222.
- Write coef[1][0]=0 at the same edge as the first MAC edge of ROW=1, A=100, B=10 → old value 4 used, XOUT=120. A second ROW=1 request with the same operands → Σ=18, XOUT=204.
- Assert RST mid-MAC → OUT_VALID=0, XOUT=0, BUSY=0 immediately; table back to defaults. After release, request A=100, B=10, ROW=1 → XOUT=120.
